// File: rtl/lv_pkg.sv
// Shared definitions for the LV-side IO conditioning path: channel indices and
// the idle level each pad is expected to rest at.
package lv_pkg;

    localparam int IO_PWM     = 0;
    localparam int IO_PWMA    = 1;
    localparam int IO_INTA    = 2;
    localparam int IO_INTB    = 3;
    localparam int IO_FSSTATE = 4;
    localparam int IO_FSENB_N = 5;

    localparam int LV_IO_NCH = 6;

    // inta, intb and fsenb_n idle high; everything else idles low
    localparam logic [LV_IO_NCH-1:0] LV_IO_RST_VAL = 6'b101100;

endpackage

// File: rtl/lv_io_flt_ch.sv
// One conditioning channel: synchroniser, stability counter, registered edge
// pulses and a sticky flag recording that a short pulse was thrown away.
module lv_io_flt_ch #(
    parameter int   SYNC_STAGES = 2,
    parameter int   FLT_W       = 4,
    parameter logic RST_BIT     = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_raw,
    input  logic [FLT_W-1:0] i_len,
    input  logic             i_glitch_clr,
    output logic             o_filt,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_glitch
);

    localparam logic [FLT_W:0] CNT_ONE = (FLT_W+1)'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FLT_W-1:0]       cnt_q;
    logic                   filt_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   glitch_q;

    logic                   sync_s;
    logic [FLT_W:0]         cnt_inc;
    logic                   differs;
    logic                   settle;
    logic                   reject;

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;
    assign differs = (sync_s != filt_q);
    // >= rather than == so a shortened length releases a long-running count at once
    assign settle  = differs && (cnt_inc >= {1'b0, i_len});
    assign reject  = !differs && (cnt_q != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q   <= {SYNC_STAGES{RST_BIT}};
            cnt_q    <= '0;
            filt_q   <= RST_BIT;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (!differs) begin
                cnt_q <= '0;
            end else if (settle) begin
                filt_q <= sync_s;
                cnt_q  <= '0;
                rise_q <= sync_s;
                fall_q <= !sync_s;
            end else begin
                cnt_q <= cnt_inc[FLT_W-1:0];
            end
            // a rejection in the same cycle as a clear must not be lost
            if (reject) begin
                glitch_q <= 1'b1;
            end else if (i_glitch_clr) begin
                glitch_q <= 1'b0;
            end
        end
    end

    assign o_filt   = filt_q;
    assign o_rise   = rise_q;
    assign o_fall   = fall_q;
    assign o_glitch = glitch_q;

endmodule

// File: rtl/lv_io_deglitch.sv
// Input conditioning for the LV core IO pins: one filter channel per pad, a
// shared filter length with zero read as one, and a scan-mode bypass.
module lv_io_deglitch
    import lv_pkg::*;
#(
    parameter int             NCH         = LV_IO_NCH,
    parameter int             SYNC_STAGES = 2,
    parameter int             FLT_W       = 4,
    parameter logic [NCH-1:0] RST_VAL     = LV_IO_RST_VAL
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_scan_mode,
    input  logic [NCH-1:0]   i_io_raw,
    input  logic [FLT_W-1:0] i_flt_len,
    input  logic             i_glitch_clr,
    output logic [NCH-1:0]   o_io_filt,
    output logic [NCH-1:0]   o_io_rise,
    output logic [NCH-1:0]   o_io_fall,
    output logic [NCH-1:0]   o_glitch_flag
);

    logic [FLT_W-1:0] len_eff;
    logic [NCH-1:0]   filt_int;
    logic [NCH-1:0]   rise_int;
    logic [NCH-1:0]   fall_int;

    assign len_eff = (i_flt_len == '0) ? FLT_W'(1) : i_flt_len;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        lv_io_flt_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FLT_W       (FLT_W),
            .RST_BIT     (RST_VAL[g])
        ) u_ch (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_raw        (i_io_raw[g]),
            .i_len        (len_eff),
            .i_glitch_clr (i_glitch_clr),
            .o_filt       (filt_int[g]),
            .o_rise       (rise_int[g]),
            .o_fall       (fall_int[g]),
            .o_glitch     (o_glitch_flag[g])
        );
    end

    // Scan bypass is purely combinational; the filters keep running behind it
    always_comb begin
        o_io_filt = filt_int;
        o_io_rise = rise_int;
        o_io_fall = fall_int;
        if (i_scan_mode) begin
            o_io_filt = i_io_raw;
            o_io_rise = '0;
            o_io_fall = '0;
        end
    end

endmodule

// File: tb/tb_lv_io_deglitch.sv
// Self-checking bench for lv_io_deglitch: directed latency/glitch/scan/reset
// scenarios plus randomized pad activity against a timestamp-based model.
module tb_lv_io_deglitch;
    import lv_pkg::*;

    localparam int NCH   = LV_IO_NCH;
    localparam int SYNC  = 2;
    localparam int FLT_W = 4;
    localparam logic [NCH-1:0] RSTV = LV_IO_RST_VAL;

    logic             clk  = 1'b0;
    logic             rst  = 1'b0;
    logic             scan = 1'b0;
    logic [NCH-1:0]   raw  = LV_IO_RST_VAL;
    logic [FLT_W-1:0] len  = 4'd4;
    logic             clr  = 1'b0;
    logic [NCH-1:0]   filt;
    logic [NCH-1:0]   rise;
    logic [NCH-1:0]   fall;
    logic [NCH-1:0]   flag;

    int n_checks = 0;
    int n_fail   = 0;

    lv_io_deglitch dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_scan_mode   (scan),
        .i_io_raw      (raw),
        .i_flt_len     (len),
        .i_glitch_clr  (clr),
        .o_io_filt     (filt),
        .o_io_rise     (rise),
        .o_io_fall     (fall),
        .o_glitch_flag (flag)
    );

    always #5 clk = ~clk;

    // Model: the synchronised level is the pad value seen SYNC edges earlier;
    // the output follows once that level has disagreed for L consecutive edges.
    logic [NCH-1:0] m_filt;
    logic [NCH-1:0] m_rise;
    logic [NCH-1:0] m_fall;
    logic [NCH-1:0] m_flag;
    logic [NCH-1:0] m_hist[$];
    int             m_since[NCH];
    int             m_edge;

    task automatic model_step();
        logic [NCH-1:0] s;
        int             l;
        logic           rejected;
        if (rst) begin
            m_filt = RSTV;
            m_rise = '0;
            m_fall = '0;
            m_flag = '0;
            m_hist.delete();
            m_edge = 0;
            for (int c = 0; c < NCH; c++) m_since[c] = -1;
        end else begin
            l = (len == '0) ? 1 : int'(len);
            s = (m_hist.size() >= SYNC) ? m_hist[0] : RSTV;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < NCH; c++) begin
                rejected = 1'b0;
                if (s[c] == m_filt[c]) begin
                    rejected   = (m_since[c] >= 0);
                    m_since[c] = -1;
                end else begin
                    if (m_since[c] < 0) m_since[c] = m_edge;
                    if (m_edge - m_since[c] + 1 >= l) begin
                        m_filt[c]  = s[c];
                        m_rise[c]  = s[c];
                        m_fall[c]  = !s[c];
                        m_since[c] = -1;
                    end
                end
                if (rejected) m_flag[c] = 1'b1;
                else if (clr) m_flag[c] = 1'b0;
            end
            m_hist.push_back(raw);
            if (m_hist.size() > SYNC) void'(m_hist.pop_front());
            m_edge++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [NCH-1:0] r, input logic [FLT_W-1:0] l,
                                 input logic c, input logic s);
        raw  = r;
        len  = l;
        clr  = c;
        scan = s;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        applyStimulus(RSTV, 4'd4, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        n_checks++;
        if (filt !== 6'b101100) begin
            n_fail++;
            $display("[TB] FAIL reset_filt: got %b expected %b", filt, 6'b101100);
        end
        n_checks++;
        if ({rise, fall, flag} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_pulses: rise %b fall %b flag %b expected all 0", rise, fall, flag);
        end
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            n_checks++;
            if (filt !== 6'b101100 || rise !== '0 || fall !== '0) begin
                n_fail++;
                $display("[TB] FAIL reset_release cycle %0d: filt %b rise %b fall %b expected 101100/0/0",
                         n, filt, rise, fall);
            end
        end
    endtask

    task automatic test_latency();
        logic [NCH-1:0] exp_f;
        applyStimulus(RSTV | 6'b000001, 4'd4, 1'b0, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            exp_f = (n >= 6) ? (6'b101100 | 6'b000001) : 6'b101100;
            n_checks++;
            if (filt !== exp_f) begin
                n_fail++;
                $display("[TB] FAIL latency_filt cycle %0d: got %b expected %b", n, filt, exp_f);
            end
            n_checks++;
            if (rise[IO_PWM] !== (n == 6) || fall !== '0) begin
                n_fail++;
                $display("[TB] FAIL latency_rise cycle %0d: rise %b fall %b expected rise0=%0d fall 0",
                         n, rise, fall, (n == 6));
            end
        end
    endtask

    task automatic test_glitch();
        applyStimulus(RSTV, 4'd4, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if (flag !== '0) begin
            n_fail++;
            $display("[TB] FAIL glitch_preclear: flag %b expected 000000", flag);
        end
        raw[IO_PWM] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 3) raw[IO_PWM] = 1'b0;
            n_checks++;
            if (filt[IO_PWM] !== 1'b0 || rise[IO_PWM] !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL glitch_filt cycle %0d: filt0 %b rise0 %b expected 0/0",
                         n, filt[IO_PWM], rise[IO_PWM]);
            end
            n_checks++;
            if (flag[IO_PWM] !== (n >= 6)) begin
                n_fail++;
                $display("[TB] FAIL glitch_flag cycle %0d: got %b expected %b", n, flag[IO_PWM], (n >= 6));
            end
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if (flag[IO_PWM] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL glitch_clear: flag0 %b expected 0", flag[IO_PWM]);
        end
    endtask

    task automatic test_len_zero();
        applyStimulus(RSTV, 4'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        raw[IO_PWM] = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            n_checks++;
            if (filt[IO_PWM] !== (n >= 3)) begin
                n_fail++;
                $display("[TB] FAIL len0_latency cycle %0d: got %b expected %b", n, filt[IO_PWM], (n >= 3));
            end
        end
        len = 4'd1;
        raw[IO_PWM] = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            n_checks++;
            if (filt[IO_PWM] !== (n < 3) || fall[IO_PWM] !== (n == 3)) begin
                n_fail++;
                $display("[TB] FAIL len1_latency cycle %0d: filt0 %b fall0 %b expected %b/%b",
                         n, filt[IO_PWM], fall[IO_PWM], (n < 3), (n == 3));
            end
        end
        repeat (2) @(negedge clk);
        raw[IO_PWM] = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) raw[IO_PWM] = 1'b0;
            n_checks++;
            if (filt[IO_PWM] !== (n == 3) || rise[IO_PWM] !== (n == 3) || fall[IO_PWM] !== (n == 4)) begin
                n_fail++;
                $display("[TB] FAIL len1_pulse cycle %0d: filt0 %b rise0 %b fall0 %b expected %b/%b/%b",
                         n, filt[IO_PWM], rise[IO_PWM], fall[IO_PWM], (n == 3), (n == 3), (n == 4));
            end
        end
    endtask

    task automatic test_len_change();
        applyStimulus(RSTV, 4'd15, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        raw[IO_PWM] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            n_checks++;
            if (filt[IO_PWM] !== (n == 8) || rise[IO_PWM] !== (n == 8)) begin
                n_fail++;
                $display("[TB] FAIL len_shrink cycle %0d: filt0 %b rise0 %b expected %b/%b",
                         n, filt[IO_PWM], rise[IO_PWM], (n == 8), (n == 8));
            end
            if (n == 7) len = 4'd2;
        end
        len = 4'd4;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        raw[IO_PWM] = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 3) raw[IO_PWM] = 1'b1;
            clr = (n == 5);
            n_checks++;
            if (flag[IO_PWM] !== (n >= 6) || filt[IO_PWM] !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL clr_vs_set cycle %0d: flag0 %b filt0 %b expected %b/1",
                         n, flag[IO_PWM], filt[IO_PWM], (n >= 6));
            end
        end
        clr = 1'b0;
    endtask

    task automatic test_scan_and_reset();
        logic [NCH-1:0] r;
        applyStimulus(RSTV, 4'd3, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            r = NCH'($urandom);
            raw = r;
            #1;
            n_checks++;
            if (filt !== r || rise !== '0 || fall !== '0) begin
                n_fail++;
                $display("[TB] FAIL scan_bypass step %0d: filt %b rise %b fall %b expected %b/0/0",
                         n, filt, rise, fall, r);
            end
        end
        applyStimulus(~RSTV, 4'd15, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (filt !== 6'b101100 || {rise, fall, flag} !== '0) begin
            n_fail++;
            $display("[TB] FAIL async_reset: filt %b rise %b fall %b flag %b expected 101100/0/0/0",
                     filt, rise, fall, flag);
        end
        raw = RSTV;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            n_checks++;
            if (filt !== 6'b101100 || rise !== '0 || fall !== '0) begin
                n_fail++;
                $display("[TB] FAIL post_reset_quiet cycle %0d: filt %b rise %b fall %b", n, filt, rise, fall);
            end
        end
        len = 4'd1;
        raw[IO_INTA] = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            n_checks++;
            if (filt[IO_INTA] !== (n < 3) || fall[IO_INTA] !== (n == 3) || rise !== '0) begin
                n_fail++;
                $display("[TB] FAIL post_reset_edge cycle %0d: filt2 %b fall2 %b rise %b expected %b/%b/0",
                         n, filt[IO_INTA], fall[IO_INTA], rise, (n < 3), (n == 3));
            end
        end
    endtask

    task automatic test_random();
        logic [NCH-1:0] exp_f;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            exp_f = scan ? raw : m_filt;
            n_checks++;
            if (filt !== exp_f) begin
                n_fail++;
                $display("[TB] FAIL rand_filt cycle %0d: got %b expected %b", n, filt, exp_f);
            end
            n_checks++;
            if (rise !== (scan ? '0 : m_rise)) begin
                n_fail++;
                $display("[TB] FAIL rand_rise cycle %0d: got %b expected %b", n, rise, (scan ? '0 : m_rise));
            end
            n_checks++;
            if (fall !== (scan ? '0 : m_fall)) begin
                n_fail++;
                $display("[TB] FAIL rand_fall cycle %0d: got %b expected %b", n, fall, (scan ? '0 : m_fall));
            end
            n_checks++;
            if (flag !== m_flag) begin
                n_fail++;
                $display("[TB] FAIL rand_flag cycle %0d: got %b expected %b", n, flag, m_flag);
            end
            raw = raw ^ (NCH'($urandom) & NCH'($urandom) & NCH'($urandom));
            clr = ($urandom_range(0, 19) == 0);
            if (n % 60 == 0) begin
                len  = ($urandom_range(0, 9) == 0) ? 4'd15 : FLT_W'($urandom_range(0, 6));
                scan = ($urandom_range(0, 7) == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_len_zero();
        test_len_change();
        test_scan_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
